// File: rtl/blink_rate_ctrl.sv
// Blink rate controller: two raw rate-select switches are synchronized and
// debounced, and the resulting 2-bit rate selects a periodic single-cycle
// enable pulse (off / 1 Hz / 10 Hz / 100 Hz) for a downstream LED toggler.
module blink_rate_ctrl #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_switch_1,
  input  logic       i_switch_2,
  output logic       o_en,
  output logic [1:0] o_rate,
  output logic       o_active
);

  // Debounce counter is never narrower than 18 bits.
  localparam int unsigned DB_W = ($clog2(DEBOUNCE_CYCLES) > 18) ? $clog2(DEBOUNCE_CYCLES) : 18;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Terminal tick counts (period minus one) for each rate.
  localparam logic [31:0] LAST_1HZ   = 32'(CLK_HZ - 1);
  localparam logic [31:0] LAST_10HZ  = 32'((CLK_HZ / 10) - 1);
  localparam logic [31:0] LAST_100HZ = 32'((CLK_HZ / 100) - 1);

  // Map a rate code to the terminal value of the tick counter.
  function automatic logic [31:0] period_last(input logic [1:0] rate);
    logic [31:0] last;
    case (rate)
      2'b01:   last = LAST_1HZ;
      2'b10:   last = LAST_10HZ;
      2'b11:   last = LAST_100HZ;
      default: last = '0;
    endcase
    return last;
  endfunction

  // Bit 0 carries switch 1, bit 1 carries switch 2 throughout.
  logic [1:0]            meta_q, meta_d;
  logic [1:0]            sync_q, sync_d;
  logic [1:0]            rate_q, rate_d;
  logic [1:0][DB_W-1:0]  cnt_q, cnt_d;
  logic [31:0]           tick_q, tick_d;
  logic                  en_q, en_d;
  logic                  active_q, active_d;
  logic                  rate_chg;

  // Two-flop synchronizer feeding the debouncers.
  always_comb begin
    meta_d = {i_switch_2, i_switch_1};
    sync_d = meta_q;
  end

  // Independent debounce per switch; the debounced pair is the rate register,
  // so simultaneous clean edges on both switches update the rate together.
  always_comb begin
    rate_d = rate_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] == rate_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        cnt_d[i]  = '0;
        rate_d[i] = sync_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Tick counter and enable pulse; a rate change restarts the period and
  // suppresses any pulse that would have fired on that same edge.
  always_comb begin
    rate_chg = (rate_d != rate_q);
    tick_d   = '0;
    en_d     = 1'b0;
    if (!rate_chg && (rate_q != 2'b00)) begin
      if (tick_q == period_last(rate_q)) begin
        en_d   = 1'b1;
        tick_d = '0;
      end else begin
        tick_d = tick_q + 32'd1;
      end
    end
    active_d = (rate_d != 2'b00);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      rate_q   <= '0;
      cnt_q    <= '0;
      tick_q   <= '0;
      en_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      rate_q   <= rate_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      en_q     <= en_d;
      active_q <= active_d;
    end
  end

  assign o_en     = en_q;
  assign o_rate   = rate_q;
  assign o_active = active_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Scoreboard bench for blink_rate_ctrl with CLK_HZ=1000, DEBOUNCE_CYCLES=4.
// Stimulus pushes expected (event, value, cycle) records; a monitor pops one
// record for every o_rate change and every o_en pulse the DUT presents.
module tb_blink_rate_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sw1;
  logic       sw2;
  logic       o_en;
  logic [1:0] o_rate;
  logic       o_active;

  blink_rate_ctrl #(
    .CLK_HZ          (1000),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_switch_1 (sw1),
    .i_switch_2 (sw2),
    .o_en       (o_en),
    .o_rate     (o_rate),
    .o_active   (o_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 = o_rate change, 1 = o_en pulse
    int val;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input bit ok, input string name, input int got, input int want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input int val);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: kind=%0d val=%0d at cycle %0d, none expected", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        bad++;
        $display("FAIL event: got kind=%0d val=%0d cycle=%0d expected kind=%0d val=%0d cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: sample away from the active edge and score every output event.
  logic [1:0] prev_rate = 2'b00;
  logic       prev_en   = 1'b0;
  always @(negedge clk) begin
    if (o_rate !== prev_rate) begin
      pop_check(0, int'(o_rate));
      check(o_active === (o_rate != 2'b00), "o_active_track", int'(o_active), int'(o_rate != 2'b00));
      prev_rate = o_rate;
    end
    if (o_en === 1'b1) begin
      pop_check(1, 1);
      check(!prev_en, "en_back_to_back", 1, 0);
    end
    prev_en = o_en;
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int r, t;

  initial begin
    rst_n = 1'b0;
    sw1   = 1'b0;
    sw2   = 1'b0;
    repeat (3) @(negedge clk);
    check(o_rate == 2'b00, "reset_rate", int'(o_rate), 0);
    check(o_en == 1'b0, "reset_en", int'(o_en), 0);
    check(o_active == 1'b0, "reset_active", int'(o_active), 0);

    // 01 from reset release: rate after 6 cycles, pulses every 1000.
    r     = cyc;
    rst_n = 1'b1;
    sw1   = 1'b1;
    push(0, 1, r + 6);
    push(1, 1, r + 1006);
    push(1, 1, r + 2006);

    // 01 -> 10 timed so the new rate lands on the edge where the old count
    // would have fired: that pulse must be suppressed.
    wait_cyc(r + 3000);
    sw1 = 1'b0;
    sw2 = 1'b1;
    push(0, 2, r + 3006);
    push(1, 1, r + 3106);
    push(1, 1, r + 3206);

    // 10 -> 00: outputs idle for 2000 cycles.
    wait_cyc(r + 3210);
    sw2 = 1'b0;
    push(0, 0, r + 3216);
    wait_cyc(r + 5216);
    check(o_rate == 2'b00, "off_rate", int'(o_rate), 0);
    check(o_active == 1'b0, "off_active", int'(o_active), 0);

    // 00 -> 11 on both switches at once, 100 Hz pulses every 10 cycles.
    t   = r + 5300;
    wait_cyc(t);
    sw1 = 1'b1;
    sw2 = 1'b1;
    push(0, 3, t + 6);
    for (int k = 0; k < 6; k++) push(1, 1, t + 16 + 10 * k);

    // 3-cycle glitch on switch 1: no rate change, pulse phase unchanged.
    wait_cyc(t + 40);
    sw1 = 1'b0;
    wait_cyc(t + 43);
    sw1 = 1'b1;

    // Reset for one cycle when the tick counter reads 9.
    wait_cyc(t + 75);
    push(0, 0, t + 76);
    rst_n = 1'b0;
    wait_cyc(t + 76);
    check(o_rate == 2'b00, "midrun_reset_rate", int'(o_rate), 0);
    check(o_en == 1'b0, "midrun_reset_en", int'(o_en), 0);
    check(o_active == 1'b0, "midrun_reset_active", int'(o_active), 0);
    rst_n = 1'b1;
    push(0, 3, t + 82);
    push(1, 1, t + 92);
    push(1, 1, t + 102);
    push(1, 1, t + 112);
    wait_cyc(t + 118);

    check(exp_q.size() == 0, "events_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
